alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU, with a single-entry response register.
// Latency: an op accepted in cycle N is presented on o_RSP_* in cycle N+1.
// Backpressure: readys drop while the response register is full and not being drained this cycle.
module alu_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        i_CLK,
  input  logic        i_RST_N,
  // requester 0
  input  logic        i_REQ0_VALID,
  output logic        o_REQ0_READY,
  input  logic [31:0] i_REQ0_OP1,
  input  logic [31:0] i_REQ0_OP2,
  input  logic [3:0]  i_REQ0_OPCODE,
  // requester 1
  input  logic        i_REQ1_VALID,
  output logic        o_REQ1_READY,
  input  logic [31:0] i_REQ1_OP1,
  input  logic [31:0] i_REQ1_OP2,
  input  logic [3:0]  i_REQ1_OPCODE,
  // shared ALU
  output logic [31:0] o_ALU_OP1,
  output logic [31:0] o_ALU_OP2,
  output logic [3:0]  o_ALU_OPCODE,
  input  logic [31:0] i_ALU_RES,
  // response
  output logic        o_RSP_VALID,
  input  logic        i_RSP_READY,
  output logic [31:0] o_RSP_RES,
  output logic        o_RSP_ID
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_rsp_res;
  logic        r_rsp_id;
  logic        r_ptr;      // requester favoured when both are valid

  logic        w_gnt_vld;
  logic        w_gnt_id;
  logic        w_can_accept;
  logic        w_accept;

  // Grant depends only on the valids and the pointer; the response slot only gates the readys.
  always_comb begin
    w_gnt_vld = i_REQ0_VALID | i_REQ1_VALID;
    w_gnt_id  = 1'b0;
    if (i_REQ0_VALID && i_REQ1_VALID) begin
      w_gnt_id = r_ptr;
    end else if (i_REQ1_VALID) begin
      w_gnt_id = 1'b1;
    end
  end

  // A full slot can still take a new op if it is being drained in the same cycle.
  assign w_can_accept = (r_state == ST_EMPTY) | i_RSP_READY;
  assign w_accept     = w_can_accept & w_gnt_vld;

  assign o_REQ0_READY = w_accept & ~w_gnt_id;
  assign o_REQ1_READY = w_accept &  w_gnt_id;

  // w_gnt_id is 0 whenever nothing is granted, so the idle ALU sees requester 0's fields.
  always_comb begin
    o_ALU_OP1    = i_REQ0_OP1;
    o_ALU_OP2    = i_REQ0_OP2;
    o_ALU_OPCODE = i_REQ0_OPCODE;
    if (w_gnt_id) begin
      o_ALU_OP1    = i_REQ1_OP1;
      o_ALU_OP2    = i_REQ1_OP2;
      o_ALU_OPCODE = i_REQ1_OPCODE;
    end
  end

  // Response FSM: an accept always (re)loads the slot; a drain without accept empties it.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_state   <= ST_EMPTY;
      r_rsp_res <= 32'h0;
      r_rsp_id  <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_state   <= ST_FULL;
            r_rsp_res <= i_ALU_RES;
            r_rsp_id  <= w_gnt_id;
          end
        end
        ST_FULL: begin
          if (w_accept) begin
            r_state   <= ST_FULL;
            r_rsp_res <= i_ALU_RES;
            r_rsp_id  <= w_gnt_id;
          end else if (i_RSP_READY) begin
            r_state   <= ST_EMPTY;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  // Round-robin pointer hands priority to the other requester after each accept; pinned to 0 otherwise.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_ptr <= 1'b0;
    end else if (!RR_EN) begin
      r_ptr <= 1'b0;
    end else if (w_accept) begin
      r_ptr <= ~w_gnt_id;
    end
  end

  assign o_RSP_VALID = (r_state == ST_FULL);
  assign o_RSP_RES   = r_rsp_res;
  assign o_RSP_ID    = r_rsp_id;

  // At most one requester is ever told it was accepted.
  a_one_ready: assert property (@(posedge i_CLK) disable iff (!i_RST_N)
    !(o_REQ0_READY && o_REQ1_READY));

  // A stalled response must not change under the consumer.
  a_hold: assert property (@(posedge i_CLK) disable iff (!i_RST_N)
    (o_RSP_VALID && !i_RSP_READY) |=> ($stable(o_RSP_RES) && $stable(o_RSP_ID) && o_RSP_VALID));

endmodule
